switch_poll_controller: RTL and testbench

//   Avalon-MM master that periodically reads the 9-bit switch PIO (offset 0) and debounces the sampled value.

---
 rtl/switch_poll_pkg.sv | 9 +
 rtl/switch_poll_tick.sv | 21 ++
 rtl/switch_poll_controller.sv | 111 +++++++++++
 tb/tb_switch_poll_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/switch_poll_pkg.sv
// switch_poll_pkg: register map, control bit and FSM encoding shared by the switch poller.
package switch_poll_pkg;
    localparam logic [1:0] REG_STABLE = 2'd0;
    localparam logic [1:0] REG_EDGE   = 2'd1;
    localparam logic [1:0] REG_MASK   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;
    localparam int         CTRL_EN_BIT = 0;
    typedef enum logic [2:0] {IDLE, WAIT, ISSUE, CAPTURE, UPDATE} state_t;
endpackage

// File: rtl/switch_poll_tick.sv
// switch_poll_tick: poll-period counter; tc_o pulses on the last cycle of each POLL_DIV period.
module switch_poll_tick #(
    parameter int POLL_DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int CW = $clog2(POLL_DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tc_o = en_i && !clr_i && (cnt_q == CW'(POLL_DIV - 1));
    always_comb begin
        cnt_d = (clr_i || tc_o) ? '0 : en_i ? cnt_q + CW'(1) : cnt_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/switch_poll_controller.sv
// switch_poll_controller: polls the switch PIO, debounces the value and exposes
// STABLE/EDGE/MASK/CTRL registers plus a maskable edge interrupt.
module switch_poll_controller
    import switch_poll_pkg::*;
#(
    parameter int WIDTH        = 9,
    parameter int POLL_DIV     = 50000,
    parameter int STABLE_COUNT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  pio_address,
    output logic        pio_read,
    input  logic [31:0] pio_readdata,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq
);
    localparam int CNTW = $clog2(STABLE_COUNT + 1);
    localparam logic [CNTW-1:0] SC = CNTW'(STABLE_COUNT);
    state_t state_q, state_d;
    logic [WIDTH-1:0] sample_q, sample_d, cand_q, cand_d, stable_q, stable_d;
    logic [WIDTH-1:0] chg_q, chg_d, mask_q, mask_d, hw_set, w1c;
    logic [CNTW-1:0]  count_q, count_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             primed_q, primed_d, en_q, en_d, irq_q;
    logic             tick_clr, tick_tc, accept, unused;
    assign unused = ^{pio_readdata[31:WIDTH], avs_writedata[31:WIDTH]};
    switch_poll_tick #(.POLL_DIV(POLL_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (tick_clr),
        .en_i    (state_q != IDLE),
        .tc_o    (tick_tc)
    );
    assign pio_address  = 2'b00;
    assign pio_read     = (state_q == ISSUE) && en_q;
    assign avs_readdata = rdata_q;
    assign irq          = irq_q;
    always_comb begin
        state_d  = state_q;
        tick_clr = 1'b0;
        case (state_q)
            IDLE:    begin
                state_d  = en_q ? WAIT : IDLE;
                tick_clr = en_q;
            end
            WAIT:    state_d = tick_tc ? ISSUE : WAIT;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = UPDATE;
            UPDATE:  state_d = WAIT;
            default: state_d = IDLE;
        endcase
        if (!en_q) state_d = IDLE;
    end
    // Disabling mid-poll drops the in-flight sample and restarts the stability count.
    always_comb begin
        sample_d = (state_q == CAPTURE) ? pio_readdata[WIDTH-1:0] : sample_q;
        cand_d   = cand_q;
        count_d  = count_q;
        accept   = 1'b0;
        if (state_q != IDLE && !en_q) begin
            count_d = '0;
        end else if (state_q == UPDATE) begin
            cand_d  = sample_q;
            count_d = (sample_q != cand_q) ? CNTW'(1) : (count_q == SC) ? SC : count_q + CNTW'(1);
            accept  = (count_d == SC);
        end
        hw_set   = (accept && primed_q) ? (stable_q ^ sample_q) : '0;
        stable_d = accept ? sample_q : stable_q;
        primed_d = primed_q | accept;
        w1c      = (avs_write && avs_address == REG_EDGE) ? avs_writedata[WIDTH-1:0] : '0;
        chg_d    = (chg_q & ~w1c) | hw_set;
        mask_d   = (avs_write && avs_address == REG_MASK) ? avs_writedata[WIDTH-1:0] : mask_q;
        en_d     = (avs_write && avs_address == REG_CTRL) ? avs_writedata[CTRL_EN_BIT] : en_q;
        rdata_d  = !avs_read                  ? rdata_q :
                   avs_address == REG_STABLE ? 32'(stable_q) :
                   avs_address == REG_EDGE   ? 32'(chg_q) :
                   avs_address == REG_MASK   ? 32'(mask_q) : 32'(en_q);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sample_q <= '0;
            cand_q   <= '0;
            count_q  <= '0;
            stable_q <= '0;
            primed_q <= 1'b0;
            chg_q    <= '0;
            mask_q   <= '0;
            en_q     <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            cand_q   <= cand_d;
            count_q  <= count_d;
            stable_q <= stable_d;
            primed_q <= primed_d;
            chg_q    <= chg_d;
            mask_q   <= mask_d;
            en_q     <= en_d;
            rdata_q  <= rdata_d;
            irq_q    <= |(chg_q & mask_q);
        end
    end
endmodule

// File: tb/tb_switch_poll_controller.sv
// tb_switch_poll_controller: directed checks of polling, debounce, EDGE/IRQ, disable and async reset.
module tb_switch_poll_controller;
    import switch_poll_pkg::*;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  pio_address;
    logic        pio_read;
    logic [31:0] pio_readdata = '0;
    logic [1:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        irq;
    logic [8:0]  sw = '0;
    logic [31:0] rv;
    int compared = 0, mismatched = 0;
    int cyc = 0, rd_count = 0, last_rd = 0, wr_cyc = 0, prev_rd = 0, rc = 0, n = 0;

    always #5 clk = ~clk;

    switch_poll_controller #(.WIDTH(9), .POLL_DIV(8), .STABLE_COUNT(3)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pio_address   (pio_address),
        .pio_read      (pio_read),
        .pio_readdata  (pio_readdata),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq)
    );

    // PIO model: data valid the cycle after the read strobe
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pio_read) begin
            pio_readdata <= {23'd0, sw};
            rd_count     <= rd_count + 1;
            last_rd      <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        wr_cyc        = cyc;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic reg_chk(input string tag, input logic [1:0] a, input logic [31:0] e);
        @(negedge clk);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        rv       = avs_readdata;
        check(tag, rv, e);
    endtask

    task automatic wait_pulse(input string tag);
        int target, k;
        target = rd_count + 1;
        k = 0;
        while (rd_count < target && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_timeout"}, 32'(rd_count >= target), 32'd1);
    endtask

    // sample lands on the next poll; returns once irq has had time to follow
    task automatic poll(input string tag, input logic [8:0] v);
        sw = v;
        wait_pulse(tag);
        check({tag, "_rd_width"}, 32'(pio_read), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1;
        check("rst_pio_read", 32'(pio_read), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_readdata", avs_readdata, 32'd0);
        check("rst_pio_addr", 32'(pio_address), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        reg_chk("rst_stable", REG_STABLE, 32'h0);
        reg_chk("rst_ctrl", REG_CTRL, 32'h0);

        // 1: enable with steady 0x0A5
        sw = 9'h0A5;
        avs_wr(REG_CTRL, 32'h1);
        poll("t1_p1", 9'h0A5);
        check("t1_first_latency", 32'(last_rd - wr_cyc), 32'd10);
        check("t1_pio_addr", 32'(pio_address), 32'd0);
        prev_rd = last_rd;
        reg_chk("t1_stable_p1", REG_STABLE, 32'h0);
        poll("t1_p2", 9'h0A5);
        check("t1_period", 32'(last_rd - prev_rd), 32'd8);
        reg_chk("t1_stable_p2", REG_STABLE, 32'h0);
        poll("t1_p3", 9'h0A5);
        reg_chk("t1_stable_p3", REG_STABLE, 32'h0A5);
        reg_chk("t1_edge", REG_EDGE, 32'h0);
        check("t1_irq", 32'(irq), 32'd0);

        // 2: bit0 drops, masked in
        avs_wr(REG_MASK, 32'h1);
        poll("t2_p1", 9'h0A4);
        reg_chk("t2_mask", REG_MASK, 32'h1);
        poll("t2_p2", 9'h0A4);
        reg_chk("t2_stable_p2", REG_STABLE, 32'h0A5);
        check("t2_irq_p2", 32'(irq), 32'd0);
        poll("t2_p3", 9'h0A4);
        reg_chk("t2_stable_p3", REG_STABLE, 32'h0A4);
        reg_chk("t2_edge", REG_EDGE, 32'h1);
        check("t2_irq", 32'(irq), 32'd1);

        // 3: clear EDGE, then bounce; only three identical samples in a row accept
        avs_wr(REG_EDGE, 32'h1);
        poll("t3_b1", 9'h0A5);
        check("t3_irq_cleared", 32'(irq), 32'd0);
        poll("t3_b2", 9'h0A5);
        reg_chk("t3_stable_b2", REG_STABLE, 32'h0A4);
        poll("t3_b3", 9'h0A4);
        reg_chk("t3_stable_b3", REG_STABLE, 32'h0A4);
        poll("t3_b4", 9'h0A5);
        reg_chk("t3_stable_b4", REG_STABLE, 32'h0A4);
        poll("t3_b5", 9'h0A5);
        reg_chk("t3_stable_b5", REG_STABLE, 32'h0A4);
        reg_chk("t3_edge_b5", REG_EDGE, 32'h0);
        poll("t3_b6", 9'h0A5);
        reg_chk("t3_stable_b6", REG_STABLE, 32'h0A5);
        reg_chk("t3_edge_b6", REG_EDGE, 32'h1);
        check("t3_irq", 32'(irq), 32'd1);

        // 4: W1C collides with a hardware set on bit0
        poll("t4_p1", 9'h0A4);
        reg_chk("t4_stable_p1", REG_STABLE, 32'h0A5);
        poll("t4_p2", 9'h0A4);
        reg_chk("t4_stable_p2", REG_STABLE, 32'h0A5);
        wait_pulse("t4_p3");
        @(posedge clk);
        @(negedge clk);
        avs_address   = REG_EDGE;
        avs_writedata = 32'h1;
        avs_write     = 1'b1;
        @(posedge clk);
        #1 avs_write = 1'b0;
        reg_chk("t4_edge_collide", REG_EDGE, 32'h1);
        check("t4_irq_collide", 32'(irq), 32'd1);
        reg_chk("t4_stable_p3", REG_STABLE, 32'h0A4);
        avs_wr(REG_EDGE, 32'h1);
        repeat (2) @(negedge clk);
        check("t4_irq_cleared", 32'(irq), 32'd0);
        reg_chk("t4_edge_cleared", REG_EDGE, 32'h0);

        // 5: disable during CAPTURE after two 0x0A5 samples
        poll("t5_p1", 9'h0A5);
        poll("t5_p2", 9'h0A5);
        reg_chk("t5_stable_p2", REG_STABLE, 32'h0A4);
        wait_pulse("t5_p3");
        avs_wr(REG_CTRL, 32'h0);
        rc = rd_count;
        repeat (20) @(posedge clk);
        #1;
        check("t5_no_reads", 32'(rd_count - rc), 32'd0);
        check("t5_pio_read", 32'(pio_read), 32'd0);
        reg_chk("t5_stable_off", REG_STABLE, 32'h0A4);
        reg_chk("t5_ctrl_off", REG_CTRL, 32'h0);
        avs_wr(REG_CTRL, 32'h1);
        wait_pulse("t5_re1");
        check("t5_restart_latency", 32'(last_rd - wr_cyc), 32'd10);
        repeat (3) @(posedge clk);
        #1;
        reg_chk("t5_stable_re1", REG_STABLE, 32'h0A4);
        poll("t5_re2", 9'h0A5);
        reg_chk("t5_stable_re2", REG_STABLE, 32'h0A4);
        poll("t5_re3", 9'h0A5);
        reg_chk("t5_stable_re3", REG_STABLE, 32'h0A5);
        reg_chk("t5_edge_re3", REG_EDGE, 32'h1);
        check("t5_irq", 32'(irq), 32'd1);

        // 6: async reset while the PIO read strobe is high
        reg_chk("t6_pre_stable", REG_STABLE, 32'h0A5);
        n = 0;
        while (!pio_read && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t6_in_issue", 32'(pio_read), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6_pio_read", 32'(pio_read), 32'd0);
        check("t6_irq", 32'(irq), 32'd0);
        check("t6_readdata", avs_readdata, 32'd0);
        rc = rd_count;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        reg_chk("t6_stable", REG_STABLE, 32'h0);
        reg_chk("t6_edge", REG_EDGE, 32'h0);
        reg_chk("t6_mask", REG_MASK, 32'h0);
        reg_chk("t6_ctrl", REG_CTRL, 32'h0);
        repeat (20) @(posedge clk);
        #1;
        check("t6_no_reads", 32'(rd_count - rc), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
